adc_scan_serial_tx: RTL and testbench
=====================================

# adc_scan_serial_tx

Parametrised multi-channel acquisition and serial-transmit controller. It scans `N_CH` analog-multiplexer channels in round-robin order and runs a two-phase start/end-of-conversion handshake with an external ADC. Each sample is sent as a UART-style frame with configurable width, parity and stop bits. It sits between the ADC/mux front end and the serial line driver; it adds conversion timeout detection and error codes.

## Interface
Parameters:
- `N_CH`, 8: channels scanned; ≥2.
- `DATA_W`, 8: ADC sample width; 1–16.
- `DIV`, 105: clock cycles per serial bit; ≥2.
- `PARITY_EN`, 0: 1 = append a parity bit after the data bits.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `CONV_TO`, 255: maximum cycles allowed per handshake phase.

Ports (`CH_W` = max(1, $clog2(`N_CH`))):
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `eoc` in 1: ADC busy flag (1 = converting).
- `data_in` in `DATA_W`: ADC result.
- `dsr` in 1: receiver ready.
- `soc` out 1: start of conversion.
- `mux_en` out 1: analog mux enable.
- `load_dato` out 1: ADC output-latch strobe.
- `canale` out `CH_W`: current channel.
- `data_out` out 1: serial line; idles high.
- `busy` out 1: high while a frame is on the line.
- `tx_done` out 1: one-cycle pulse after a frame completes.
- `error` out 1: an error is pending.
- `err_code` out 2: 0 = none, 1 = eoc-rise timeout, 2 = eoc-fall timeout, 3 = dsr low.

## Operation
- All outputs are registered. After `reset`: `soc`, `mux_en`, `load_dato`, `busy`, `tx_done`, `error` = 0; `err_code` = 0; `canale` = 0; `data_out` = 1; state = MUX.
- MUX (1 cycle): `mux_en` = 1 → ACK.
- ACK: `soc` = 1 and `mux_en` = 1 until `eoc` = 1 is sampled → CONV, `soc` = 0. If `CONV_TO` cycles pass first: `error` = 1, code 1 → NEXT.
- CONV: wait for `eoc` = 0 → LOAD. If `CONV_TO` cycles pass first: code 2 → NEXT.
- LOAD (1 cycle): `load_dato` = 1, `mux_en` = 0, capture `data_in` → TX.
- TX entry: if `dsr` = 0, `error` = 1, code 3, no frame is sent → NEXT.
- TX frame: start bit 0; data MSB first; parity bit if enabled; `STOP_BITS` × 1. Each bit is held `DIV` cycles. `busy` = 1 for the whole frame.
- On a successful frame end: `tx_done` pulses, then `error` and `err_code` clear → NEXT.
- NEXT (1 cycle): `canale` ← `canale` + 1; wraps from `N_CH`−1 to 0 → MUX. Channels that error out are still advanced.
- `error` and `err_code` are sticky: each new error overwrites the code, and only a successful frame clears it.
- Parity = XOR of the data bits, inverted when `PARITY_ODD` = 1.
- `dsr` is not rechecked mid-frame.
- `eoc` is ignored outside ACK and CONV.

## Timing
- Reset release to first `soc` = 1: 2 cycles.
- Frame length F = `DIV` × (1 + `DATA_W` + `PARITY_EN` + `STOP_BITS`). Defaults: F = 1050 cycles.
- `data_out` changes only on bit boundaries. The start bit begins the cycle after LOAD.
- `tx_done` is high in the cycle after the last stop-bit cycle.
- Timeout counter: width $clog2(`CONV_TO`+1); reset on every phase entry. Timeout fires when the count reaches `CONV_TO`.
- Baud counter: width $clog2(`DIV`); counts 0..`DIV`−1 and wraps.
- `reset` mid-frame: `data_out` = 1 next cycle; frame abandoned; `canale` = 0.
- If `eoc` rises and falls while `soc` is high, only the rise is seen. Completion still requires a later `eoc` = 0.

## Structure
- Shared package `adc_scan_pkg`:
  - scan-state enum (MUX, ACK, CONV, LOAD, TX, NEXT);
  - `err_code` constants;
  - frame-length function.
- Sub-module `serial_frame_tx`:
  - parameters `DATA_W`, `DIV`, `PARITY_EN`, `PARITY_ODD`, `STOP_BITS`;
  - ports `start`, `data`, `data_out`, `busy`, `done`;
  - contains the baud counter, bit counter and shift register.
- Top level holds the scan FSM, the timeout counter and the channel counter.

## Test plan
- Defaults; ADC model raises `eoc` 3 cycles after `soc` and drops it 10 cycles later, `data_in` = 8'hA5, `dsr` = 1 → `data_out` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 105 cycles; `tx_done` pulses once; `canale` goes 0→1.
- `N_CH` = 3, 7 conversions → `canale` sequence 0,1,2,0,1,2,0.
- `eoc` held at 0, `CONV_TO` = 15 → `error` = 1 and `err_code` = 1 exactly 15 cycles after ACK entry; no frame sent; `canale` advances.
- `dsr` = 0 at TX entry → `err_code` = 3, `data_out` stays 1. The next conversion with `dsr` = 1 clears `error` after its `tx_done`.
- `PARITY_EN` = 1, `PARITY_ODD` = 1, `STOP_BITS` = 2, `DIV` = 4, data 8'h03 → parity bit 1; frame length 48 cycles.
- `reset` asserted mid-data-bit → next cycle `data_out` = 1, `busy` = 0, `canale` = 0; `soc` reasserts 2 cycles after `reset` drops.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the ADC scan / serial transmit block.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    S_MUX,
    S_ACK,
    S_CONV,
    S_LOAD,
    S_TX,
    S_NEXT
  } scan_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_EOC_RISE = 2'd1;
  localparam logic [1:0] ERR_EOC_FALL = 2'd2;
  localparam logic [1:0] ERR_DSR_LOW  = 2'd3;

  function automatic int frame_bits(input int data_w, input int parity_en,
                                    input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

  function automatic int frame_len(input int div, input int data_w,
                                   input int parity_en, input int stop_bits);
    return div * frame_bits(data_w, parity_en, stop_bits);
  endfunction

endpackage

// File: rtl/adc_scan_serial_tx_frame.sv
// UART-style frame serialiser: start bit, data MSB first, optional parity, stop bits.
module serial_frame_tx
  import adc_scan_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV        = 105,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              data_out,
  output logic              busy,
  output logic              done
);

  localparam int NB   = frame_bits(DATA_W, PARITY_EN, STOP_BITS);
  localparam int BD_W = $clog2(DIV);
  localparam int BC_W = $clog2(NB);

  logic [BD_W-1:0] baud_cnt;
  logic [BC_W-1:0] bit_cnt;
  logic [NB-2:0]   shreg;

  // Everything after the start bit, LSB of the vector goes out first.
  function automatic logic [NB-2:0] build_frame(input logic [DATA_W-1:0] d);
    logic [NB-2:0] f;
    f = '1;
    for (int i = 0; i < DATA_W; i++) f[i] = d[DATA_W-1-i];
    if (PARITY_EN != 0) f[DATA_W] = (^d) ^ (PARITY_ODD != 0);
    return f;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          shreg    <= build_frame(data);
          data_out <= 1'b0;
          busy     <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      end else if (baud_cnt == BD_W'(DIV - 1)) begin
        baud_cnt <= '0;
        if (bit_cnt == BC_W'(NB - 1)) begin
          data_out <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b1;
        end else begin
          bit_cnt  <= bit_cnt + 1'b1;
          data_out <= shreg[0];
          shreg    <= {1'b1, shreg[NB-2:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_serial_tx.sv
// Round-robin ADC channel scanner with SOC/EOC handshake, timeout errors and serial output.
module adc_scan_serial_tx
  import adc_scan_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int DATA_W     = 8,
  parameter int DIV        = 105,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int CONV_TO    = 255,
  localparam int CH_W      = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              eoc,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dsr,
  output logic              soc,
  output logic              mux_en,
  output logic              load_dato,
  output logic [CH_W-1:0]   canale,
  output logic              data_out,
  output logic              busy,
  output logic              tx_done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int TO_W = $clog2(CONV_TO + 1);

  scan_state_t     state;
  logic [TO_W-1:0] tmo_cnt;
  logic            tx_start;
  logic            tmo_hit;

  // The frame is launched from LOAD so the start bit lands the cycle after it.
  assign tx_start = (state == S_LOAD) && dsr;
  assign tmo_hit  = (tmo_cnt == TO_W'(CONV_TO - 1));

  serial_frame_tx #(
    .DATA_W    (DATA_W),
    .DIV       (DIV),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD),
    .STOP_BITS (STOP_BITS)
  ) u_frame (
    .clock   (clock),
    .reset   (reset),
    .start   (tx_start),
    .data    (data_in),
    .data_out(data_out),
    .busy    (busy),
    .done    (tx_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_MUX;
      soc       <= 1'b0;
      mux_en    <= 1'b0;
      load_dato <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
      canale    <= '0;
      tmo_cnt   <= '0;
    end else begin
      load_dato <= 1'b0;
      case (state)
        S_MUX: begin
          mux_en  <= 1'b1;
          tmo_cnt <= '0;
          state   <= S_ACK;
        end
        S_ACK: begin
          if (eoc) begin
            soc     <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_CONV;
          end else if (tmo_hit) begin
            soc      <= 1'b0;
            mux_en   <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_EOC_RISE;
            state    <= S_NEXT;
          end else begin
            soc     <= 1'b1;
            mux_en  <= 1'b1;
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CONV: begin
          if (!eoc) begin
            load_dato <= 1'b1;
            mux_en    <= 1'b0;
            state     <= S_LOAD;
          end else if (tmo_hit) begin
            mux_en   <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_EOC_FALL;
            state    <= S_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (dsr) begin
            state <= S_TX;
          end else begin
            error    <= 1'b1;
            err_code <= ERR_DSR_LOW;
            state    <= S_NEXT;
          end
        end
        S_TX: begin
          if (tx_done) begin
            error    <= 1'b0;
            err_code <= ERR_NONE;
            state    <= S_NEXT;
          end
        end
        S_NEXT: begin
          canale <= (canale == CH_W'(N_CH - 1)) ? '0 : canale + 1'b1;
          state  <= S_MUX;
        end
        default: state <= S_MUX;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_serial_tx.sv
// Directed bench: default-config DUT (A) and a small parity/timeout config DUT (B).
module tb_adc_scan_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DUT A: default parameters
  logic       reset_a, eoc_a, dsr_a;
  logic [7:0] data_in_a;
  logic       soc_a, mux_en_a, load_dato_a, data_out_a, busy_a, tx_done_a, error_a;
  logic [2:0] canale_a;
  logic [1:0] err_code_a;
  logic       adc_en_a;
  int         cnt_a;

  // DUT B: N_CH=3, DIV=4, odd parity, 2 stop bits, CONV_TO=15
  logic       reset_b, eoc_b, dsr_b;
  logic [7:0] data_in_b;
  logic       soc_b, mux_en_b, load_dato_b, data_out_b, busy_b, tx_done_b, error_b;
  logic [1:0] canale_b;
  logic [1:0] err_code_b;
  logic       adc_en_b;
  int         cnt_b;

  adc_scan_serial_tx dut_a (
    .clock(clk), .reset(reset_a), .eoc(eoc_a), .data_in(data_in_a), .dsr(dsr_a),
    .soc(soc_a), .mux_en(mux_en_a), .load_dato(load_dato_a), .canale(canale_a),
    .data_out(data_out_a), .busy(busy_a), .tx_done(tx_done_a), .error(error_a),
    .err_code(err_code_a)
  );

  adc_scan_serial_tx #(
    .N_CH(3), .DATA_W(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(1),
    .STOP_BITS(2), .CONV_TO(15)
  ) dut_b (
    .clock(clk), .reset(reset_b), .eoc(eoc_b), .data_in(data_in_b), .dsr(dsr_b),
    .soc(soc_b), .mux_en(mux_en_b), .load_dato(load_dato_b), .canale(canale_b),
    .data_out(data_out_b), .busy(busy_b), .tx_done(tx_done_b), .error(error_b),
    .err_code(err_code_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC models: eoc rises a few cycles after soc and falls 10 cycles later
  initial begin
    eoc_a = 1'b0; cnt_a = 0;
    forever begin
      @(negedge clk);
      if (!adc_en_a) begin
        eoc_a = 1'b0; cnt_a = 0;
      end else if (cnt_a != 0) begin
        cnt_a++;
        if (cnt_a == 4) eoc_a = 1'b1;
        if (cnt_a == 14) begin eoc_a = 1'b0; cnt_a = 0; end
      end else if (soc_a) begin
        cnt_a = 1;
      end
    end
  end

  initial begin
    eoc_b = 1'b0; cnt_b = 0;
    forever begin
      @(negedge clk);
      if (!adc_en_b) begin
        eoc_b = 1'b0; cnt_b = 0;
      end else if (cnt_b != 0) begin
        cnt_b++;
        if (cnt_b == 4) eoc_b = 1'b1;
        if (cnt_b == 14) begin eoc_b = 1'b0; cnt_b = 0; end
      end else if (soc_b) begin
        cnt_b = 1;
      end
    end
  end

  task automatic wait_load_a(input int max_cyc);
    int n = 0;
    do begin @(negedge clk); n++; end while (load_dato_a !== 1'b1 && n < max_cyc);
    check("a_load_wait", load_dato_a, 1);
  endtask

  task automatic wait_load_b(input int max_cyc);
    int n = 0;
    do begin @(negedge clk); n++; end while (load_dato_b !== 1'b1 && n < max_cyc);
    check("b_load_wait", load_dato_b, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seq_a[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit seq_b[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [1:0] ch_exp[4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    reset_a = 1'b1; dsr_a = 1'b1; data_in_a = 8'hA5; adc_en_a = 1'b1;
    reset_b = 1'b1; dsr_b = 1'b0; data_in_b = 8'h03; adc_en_b = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_soc", soc_a, 0);
    check("rst_mux_en", mux_en_a, 0);
    check("rst_load_dato", load_dato_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_tx_done", tx_done_a, 0);
    check("rst_error", error_a, 0);
    check("rst_err_code", err_code_a, 0);
    check("rst_canale", canale_a, 0);
    check("rst_data_out", data_out_a, 1);

    reset_a = 1'b0;
    @(negedge clk);
    check("a_soc_c1", soc_a, 0);
    check("a_mux_en_c1", mux_en_a, 1);
    @(negedge clk);
    check("a_soc_c2", soc_a, 1);

    // First frame on A: 8'hA5, 105 cycles per bit
    wait_load_a(200);
    check("a_load_canale", canale_a, 0);
    check("a_load_data_out", data_out_a, 1);
    for (int c = 1; c <= 1050; c++) begin
      int ph;
      @(negedge clk);
      ph = (c - 1) % 105;
      if (ph == 0 || ph == 104)
        check($sformatf("a_bit%0d_ph%0d", (c - 1) / 105, ph), data_out_a, seq_a[(c - 1) / 105]);
      if (c == 1 || c == 1050) check($sformatf("a_busy_c%0d", c), busy_a, 1);
      if (c == 1050) check("a_tx_done_early", tx_done_a, 0);
    end
    @(negedge clk);
    check("a_tx_done", tx_done_a, 1);
    check("a_busy_end", busy_a, 0);
    @(negedge clk);
    check("a_tx_done_once", tx_done_a, 0);
    check("a_error_clear", error_a, 0);
    repeat (3) @(negedge clk);
    check("a_canale_next", canale_a, 1);

    // Second frame on A: reset in the middle of frame bit 2 (a zero)
    wait_load_a(200);
    repeat (260) @(negedge clk);
    check("a_mid_bit", data_out_a, 0);
    reset_a = 1'b1;
    @(negedge clk);
    check("a_rst_data_out", data_out_a, 1);
    check("a_rst_busy", busy_a, 0);
    check("a_rst_canale", canale_a, 0);
    reset_a = 1'b0;
    @(negedge clk);
    check("a_rerun_soc_c1", soc_a, 0);
    @(negedge clk);
    check("a_rerun_soc_c2", soc_a, 1);

    // B: eoc stuck low -> rise timeout after 15 cycles
    reset_b = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 15) check("b_err_c15", error_b, 0);
      if (c == 16) begin
        check("b_err_c16", error_b, 1);
        check("b_code_c16", err_code_b, 1);
        check("b_data_out_to", data_out_b, 1);
      end
      if (c == 17) begin
        check("b_canale_to", canale_b, 1);
        check("b_busy_to", busy_b, 0);
      end
    end
    adc_en_b = 1'b1;

    // B: dsr low at TX entry
    wait_load_b(60);
    check("b_dsr_canale", canale_b, 1);
    @(negedge clk);
    check("b_dsr_error", error_b, 1);
    check("b_dsr_code", err_code_b, 3);
    check("b_dsr_busy", busy_b, 0);
    repeat (4) @(negedge clk);
    check("b_dsr_data_out", data_out_b, 1);
    dsr_b = 1'b1;

    // B: 8'h03 with odd parity and two stop bits, 48-cycle frame
    wait_load_b(60);
    check("b_frame_canale", canale_b, 2);
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if ((c - 1) % 4 == 0)
        check($sformatf("b_bit%0d", (c - 1) / 4), data_out_b, seq_b[(c - 1) / 4]);
      if (c == 48) check("b_busy_last", busy_b, 1);
    end
    @(negedge clk);
    check("b_tx_done", tx_done_b, 1);
    check("b_busy_end", busy_b, 0);
    check("b_error_sticky", error_b, 1);
    @(negedge clk);
    check("b_error_clear", error_b, 0);
    check("b_code_clear", err_code_b, 0);

    // B: channel wrap over further conversions
    for (int i = 0; i < 4; i++) begin
      wait_load_b(100);
      check($sformatf("b_scan%0d_canale", i), canale_b, ch_exp[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
